// File: rtl/register_file_responder_pkg.sv
// register_file_responder_pkg
//   Shared constants and state encodings for the register file responder:
//   data/index widths, register count and the CLEAR/IDLE state type.
package register_file_responder_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int REG_COUNT  = 1 << ADDR_WIDTH;

   typedef enum logic {
      REGF_STATE_CLEAR = 1'b0,
      REGF_STATE_IDLE  = 1'b1
   } regf_state_t;

endpackage

// File: rtl/register_file_responder_clear_seq.sv
// reg_file_clear_seq
//   Post-reset zeroing sequencer. Owns the CLEAR/IDLE state, the sweep
//   pointer and BUSY. RST restarts the sweep from index 0.
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset
//   clear_ptr  index being zeroed this cycle
//   clear_we   high while the sweep is writing clear_ptr
//   BUSY       high while the sweep runs (state == CLEAR)
module reg_file_clear_seq
   import register_file_responder_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   output logic [ADDR_WIDTH-1:0] clear_ptr,
   output logic                  clear_we,
   output logic                  BUSY
);

   regf_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  sweep_done;

   assign sweep_done = (ptr_q == ADDR_WIDTH'(REG_COUNT - 1));
   assign clear_ptr  = ptr_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= REGF_STATE_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // BUSY decodes the registered state, so it drops on the same edge that
   // writes the last index.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      clear_we = 1'b0;
      BUSY     = 1'b0;
      case (state_q)
         REGF_STATE_CLEAR: begin
            BUSY     = 1'b1;
            clear_we = 1'b1;
            ptr_d    = ptr_q + 1'b1;
            if (sweep_done) state_d = REGF_STATE_IDLE;
         end
         REGF_STATE_IDLE: begin
            ptr_d = '0;
         end
         default: begin
            state_d = REGF_STATE_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/register_file_responder.sv
// register_file_responder
//   Two-read / one-write register file for the control unit. Reads are
//   registered (one-edge latency), writes commit once per WRITE assertion,
//   ACK pulses one cycle after a serviced request. Register 0 reads as zero.
//   All registers are zeroed by a 32-cycle sweep after reset (BUSY high).
// Optional build macro:
//   REGFILE_BYPASS_EN  same-edge read/write hit to a nonzero index returns
//                      DATA_W instead of the pre-write contents.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   READ, WRITE         level requests
//   ADDR_R1, ADDR_R2    read indices
//   ADDR_W, DATA_W      write index / data
//   DATA_R1, DATA_R2    registered read data
//   BUSY                clear sweep in progress, requests ignored
//   ACK                 one-cycle service pulse
module register_file_responder
   import register_file_responder_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDR_R1,
   input  logic [ADDR_WIDTH-1:0] ADDR_R2,
   input  logic [ADDR_WIDTH-1:0] ADDR_W,
   input  logic [DATA_WIDTH-1:0] DATA_W,
   output logic [DATA_WIDTH-1:0] DATA_R1,
   output logic [DATA_WIDTH-1:0] DATA_R2,
   output logic                  BUSY,
   output logic                  ACK
);

   logic [DATA_WIDTH-1:0] mem [REG_COUNT];
   logic [ADDR_WIDTH-1:0] clear_ptr;
   logic                  clear_we;
   logic                  idle;
   logic                  read_prev, write_prev;
   logic                  wr_commit, wr_en_mem;
   logic [DATA_WIDTH-1:0] rd1_val, rd2_val;

   reg_file_clear_seq u_clear_seq (
      .CLK       (CLK),
      .RST       (RST),
      .clear_ptr (clear_ptr),
      .clear_we  (clear_we),
      .BUSY      (BUSY)
   );

   assign idle      = ~BUSY;
   // A write on the reset edge is dropped, hence the ~RST gate.
   assign wr_commit = idle & WRITE & ~write_prev & ~RST;
   assign wr_en_mem = wr_commit & (ADDR_W != '0);

   always_comb begin
      rd1_val = mem[ADDR_R1];
      rd2_val = mem[ADDR_R2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en_mem && (ADDR_R1 == ADDR_W)) rd1_val = DATA_W;
      if (wr_en_mem && (ADDR_R2 == ADDR_W)) rd2_val = DATA_W;
`endif
      if (ADDR_R1 == '0) rd1_val = '0;
      if (ADDR_R2 == '0) rd2_val = '0;
   end

   // Storage has no reset branch; the sweep zeroes it starting on the first
   // edge with RST low.
   always_ff @(posedge CLK) begin
      if (clear_we && !RST)
         mem[clear_ptr] <= '0;
      else if (wr_en_mem)
         mem[ADDR_W] <= DATA_W;
   end

   // Edge detectors are held at 0 during CLEAR so a request held through
   // the sweep is serviced on the first IDLE edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         DATA_R1    <= '0;
         DATA_R2    <= '0;
         ACK        <= 1'b0;
         read_prev  <= 1'b0;
         write_prev <= 1'b0;
      end else begin
         read_prev  <= idle & READ;
         write_prev <= idle & WRITE;
         ACK        <= idle & ((READ & ~read_prev) | (WRITE & ~write_prev));
         if (idle && READ) begin
            DATA_R1 <= rd1_val;
            DATA_R2 <= rd2_val;
         end
      end
   end

endmodule
